// File: rtl/sr_counter_pkg.sv
// Shared definitions for the SR-cell mode counter: mode codes and the
// encoding helpers used by the counter's next-state and output logic.
package sr_counter_pkg;

    localparam logic [1:0] MODE_BIN_UP  = 2'b00;
    localparam logic [1:0] MODE_BIN_DN  = 2'b01;
    localparam logic [1:0] MODE_GRAY    = 2'b10;
    localparam logic [1:0] MODE_JOHNSON = 2'b11;

    // Binary to reflected Gray code; callers truncate to their own width.
    function automatic logic [15:0] bin2gray(input logic [15:0] b);
        return b ^ (b >> 1);
    endfunction

    // A w-bit Johnson code is legal when it is a run of ones at the bottom
    // (0..01..1) or a run of ones at the top (1..10..0), all-0/all-1 included.
    // The 17-bit working width keeps the +1 from overflowing at w == 16.
    function automatic logic johnson_legal(input logic [15:0] v, input int w);
        logic [16:0] mask;
        logic [16:0] lo;
        logic [16:0] hi;
        mask = (17'd1 << w) - 17'd1;
        lo   = {1'b0, v} & mask;
        hi   = ~{1'b0, v} & mask;
        return (((lo & (lo + 17'd1)) & mask) == 17'd0) ||
               (((hi & (hi + 17'd1)) & mask) == 17'd0);
    endfunction

endpackage

// File: rtl/sr_mode_counter_if.sv
// Control and status bundle of one counter stage. The master side drives the
// controls and observes the count; the counter itself takes the slave side.
interface sr_mode_counter_if #(parameter int WIDTH = 4) ();

    logic             i_en;
    logic             i_clr;
    logic             i_load;
    logic [WIDTH-1:0] i_load_val;
    logic [1:0]       i_mode;
    logic [WIDTH-1:0] o_q;
    logic [WIDTH-1:0] o_q_n;
    logic             o_tc;
    logic             o_wrap;

    modport master (
        output i_en, i_clr, i_load, i_load_val, i_mode,
        input  o_q, o_q_n, o_tc, o_wrap
    );

    modport slave (
        input  i_en, i_clr, i_load, i_load_val, i_mode,
        output o_q, o_q_n, o_tc, o_wrap
    );

endinterface

// File: rtl/srff_cell.sv
// Single-bit SR storage cell with asynchronous active-low clear to 0.
// The driver guarantees set and reset are never asserted together; if they
// were, the cell simply holds.
module srff_cell (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_s,
    input  logic i_r,
    output logic o_q,
    output logic o_q_n
);

    logic r_q;

    // Set forces 1, reset forces 0, neither (or both) holds the stored bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= 1'b0;
        end else if (i_s && !i_r) begin
            r_q <= 1'b1;
        end else if (i_r && !i_s) begin
            r_q <= 1'b0;
        end
    end

    assign o_q   = r_q;
    assign o_q_n = ~r_q;

endmodule

// File: rtl/sr_mode_counter.sv
// Mode-selectable counter (binary up/down with modulus, Gray, Johnson) whose
// state lives in one SR cell per bit. The top computes the desired next count
// and converts it into set/reset pulses for each cell.
module sr_mode_counter
    import sr_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    sr_mode_counter_if.slave   bus
);

    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [WIDTH-1:0] JOHN_TERM = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] w_cnt;
    logic [WIDTH-1:0] w_cnt_n;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_rst;
    logic [WIDTH-1:0] w_q;
    logic             w_wrap_nxt;
    logic             w_term;
    logic             r_wrap;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        srff_cell u_cell (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_s     (w_set[gi]),
            .i_r     (w_rst[gi]),
            .o_q     (w_cnt[gi]),
            .o_q_n   (w_cnt_n[gi])
        );
    end

    // Only bits that must change get a pulse, so S and R are mutually exclusive.
    assign w_set = w_nxt & w_cnt_n;
    assign w_rst = ~w_nxt & w_cnt;

    // Next count with priority clear > load > count enable; wrap only from counting.
    always_comb begin
        w_nxt      = w_cnt;
        w_wrap_nxt = 1'b0;
        if (bus.i_clr) begin
            w_nxt = '0;
        end else if (bus.i_load) begin
            if (bus.i_mode == MODE_JOHNSON || bus.i_mode == MODE_GRAY) begin
                w_nxt = bus.i_load_val;
            end else if (bus.i_load_val > MAX_VAL) begin
                w_nxt = MAX_VAL;
            end else begin
                w_nxt = bus.i_load_val;
            end
        end else if (bus.i_en) begin
            case (bus.i_mode)
                MODE_BIN_UP: begin
                    if (w_cnt >= MAX_VAL) begin
                        w_nxt      = '0;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_nxt = w_cnt + 1'b1;
                    end
                end
                MODE_BIN_DN: begin
                    if (w_cnt == '0) begin
                        w_nxt      = MAX_VAL;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_nxt = w_cnt - 1'b1;
                    end
                end
                MODE_GRAY: begin
                    w_nxt      = w_cnt + 1'b1;
                    w_wrap_nxt = (w_cnt == ALL_ONES);
                end
                default: begin
                    if (!johnson_legal(16'(w_cnt), WIDTH)) begin
                        w_nxt = '0;
                    end else begin
                        w_nxt      = {w_cnt[WIDTH-2:0], ~w_cnt[WIDTH-1]};
                        w_wrap_nxt = (w_cnt == JOHN_TERM);
                    end
                end
            endcase
        end
    end

    // Terminal-state detect for the cascade carry, selected by the current mode.
    always_comb begin
        w_term = 1'b0;
        case (bus.i_mode)
            MODE_BIN_UP: w_term = (w_cnt == MAX_VAL);
            MODE_BIN_DN: w_term = (w_cnt == '0);
            MODE_GRAY:   w_term = (w_cnt == ALL_ONES);
            default:     w_term = (w_cnt == JOHN_TERM);
        endcase
    end

    // One-cycle wrap pulse registered from the counting edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_nxt;
        end
    end

    assign w_q       = (bus.i_mode == MODE_GRAY) ? WIDTH'(bin2gray(16'(w_cnt))) : w_cnt;
    assign bus.o_q    = w_q;
    assign bus.o_q_n  = ~w_q;
    assign bus.o_tc   = bus.i_en & i_rst_n & w_term;
    assign bus.o_wrap = r_wrap;

endmodule

// File: tb/tb_sr_mode_counter.sv
// Directed and randomized bench for sr_mode_counter (WIDTH=4, MODULUS=10),
// plus a two-stage cascade forming a decimal 0..99 counter.
module tb_sr_mode_counter;
    import sr_counter_pkg::*;

    localparam int W    = 4;
    localparam int MOD  = 10;
    localparam int JLEN = 2 * W;
    localparam int TOP  = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sr_mode_counter_if #(.WIDTH(W)) bus ();
    sr_mode_counter_if #(.WIDTH(W)) cb1 ();
    sr_mode_counter_if #(.WIDTH(W)) cb2 ();

    sr_mode_counter #(.WIDTH(W), .MODULUS(MOD)) dut   (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
    sr_mode_counter #(.WIDTH(W), .MODULUS(MOD)) u_c1  (.i_clk(clk), .i_rst_n(rst_n), .bus(cb1));
    sr_mode_counter #(.WIDTH(W), .MODULUS(MOD)) u_c2  (.i_clk(clk), .i_rst_n(rst_n), .bus(cb2));

    assign cb2.i_en = cb1.o_tc;

    int nChecks = 0;
    int nPass   = 0;

    int mCnt;
    bit mWrap;
    int curEn;
    int curMode;
    int grayTab[1 << W];
    int johnTab[JLEN];

    // Position of a value in the Johnson sequence, -1 when not a sequence member.
    function automatic int johnIndex(input int v);
        for (int i = 0; i < JLEN; i++) begin
            if (johnTab[i] == v) return i;
        end
        return -1;
    endfunction

    function automatic int expQ();
        return (curMode == 2) ? grayTab[mCnt] : mCnt;
    endfunction

    function automatic int expTc();
        int term;
        case (curMode)
            0:       term = (mCnt == MOD - 1);
            1:       term = (mCnt == 0);
            2:       term = (mCnt == TOP);
            default: term = (mCnt == johnTab[JLEN-1]);
        endcase
        return (rst_n === 1'b1 && curEn != 0 && term != 0) ? 1 : 0;
    endfunction

    // Reference behaviour of one rising edge, in terms of counter positions.
    task automatic modelEdge(input int en, input int clr, input int load, input int lv, input int mode);
        int idx;
        bit w;
        w = 1'b0;
        if (clr != 0) begin
            mCnt = 0;
        end else if (load != 0) begin
            if (mode >= 2) mCnt = lv;
            else           mCnt = (lv > MOD - 1) ? MOD - 1 : lv;
        end else if (en != 0) begin
            case (mode)
                0: begin
                    if (mCnt + 1 >= MOD) begin mCnt = 0; w = 1'b1; end
                    else mCnt = mCnt + 1;
                end
                1: begin
                    if (mCnt == 0) begin mCnt = MOD - 1; w = 1'b1; end
                    else mCnt = mCnt - 1;
                end
                2: begin
                    mCnt = (mCnt + 1) % (1 << W);
                    w = (mCnt == 0);
                end
                default: begin
                    idx = johnIndex(mCnt);
                    if (idx < 0) mCnt = 0;
                    else begin
                        mCnt = johnTab[(idx + 1) % JLEN];
                        w = (idx == JLEN - 1);
                    end
                end
            endcase
        end
        mWrap = w;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Drive one set of controls, clock once, advance the model, settle past the edge.
    task automatic applyStimulus(input int en, input int clr, input int load, input int lv, input int mode);
        bus.i_en       = (en != 0);
        bus.i_clr      = (clr != 0);
        bus.i_load     = (load != 0);
        bus.i_load_val = W'(lv);
        bus.i_mode     = 2'(mode);
        curEn   = en;
        curMode = mode;
        @(posedge clk);
        modelEdge(en, clr, load, lv, mode);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        check({tag, " q"},    32'(bus.o_q),    32'(expQ()));
        check({tag, " q_n"},  32'(bus.o_q_n),  32'((~expQ()) & TOP));
        check({tag, " tc"},   32'(bus.o_tc),   32'(expTc()));
        check({tag, " wrap"}, 32'(bus.o_wrap), 32'(mWrap));
    endtask

    initial begin
        int prevQ;
        int wrapCount;
        int holdVal;
        int en, clr, load, lv, mode;

        grayTab[0] = 0;
        for (int k = 0; k < W; k++) begin
            for (int i = 0; i < (1 << k); i++) begin
                grayTab[(1 << k) + i] = (1 << k) | grayTab[(1 << k) - 1 - i];
            end
        end
        for (int k = 0; k <= W; k++) johnTab[k] = (1 << k) - 1;
        for (int k = 1; k < W; k++) johnTab[W + k] = TOP ^ ((1 << k) - 1);

        rst_n = 1'b0;
        bus.i_en = 1'b0; bus.i_clr = 1'b0; bus.i_load = 1'b0; bus.i_load_val = '0; bus.i_mode = 2'b00;
        cb1.i_en = 1'b0; cb1.i_clr = 1'b0; cb1.i_load = 1'b0; cb1.i_load_val = '0; cb1.i_mode = MODE_BIN_UP;
        cb2.i_clr = 1'b0; cb2.i_load = 1'b0; cb2.i_load_val = '0; cb2.i_mode = MODE_BIN_UP;
        curEn = 0; curMode = 0; mCnt = 0; mWrap = 1'b0;
        #12;
        rst_n = 1'b1;

        $display("[TB] test 1: async reset mid-count");
        for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t1 at7");
        #2;
        rst_n = 1'b0;
        #1;
        mCnt = 0; mWrap = 1'b0;
        check("t1 rst q",    32'(bus.o_q),    32'd0);
        check("t1 rst q_n",  32'(bus.o_q_n),  32'd15);
        check("t1 rst tc",   32'(bus.o_tc),   32'd0);
        check("t1 rst wrap", 32'(bus.o_wrap), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] test 2: binary up modulus 10");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            checkOutput("t2 up");
        end
        check("t2 final q", 32'(bus.o_q), 32'd2);

        $display("[TB] test 3: binary down, load clamp, clear priority");
        applyStimulus(0, 1, 0, 0, 1);
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1, 0, 0, 0, 1);
            checkOutput("t3 dn");
        end
        applyStimulus(1, 0, 1, 13, 1);
        check("t3 clamp q", 32'(bus.o_q), 32'd9);
        applyStimulus(1, 1, 1, 13, 1);
        check("t3 clr>load q", 32'(bus.o_q), 32'd0);
        checkOutput("t3 clr");

        $display("[TB] test 4: Gray mode");
        applyStimulus(0, 1, 0, 0, 2);
        prevQ = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 0, 0, 0, 2);
            checkOutput("t4 gray");
            check("t4 hamming", 32'($countones(W'(bus.o_q) ^ W'(prevQ))), 32'd1);
            prevQ = int'(bus.o_q);
        end
        check("t4 wrap", 32'(bus.o_wrap), 32'd1);

        $display("[TB] test 5: Johnson mode and illegal recovery");
        applyStimulus(0, 1, 0, 0, 3);
        for (int i = 0; i < JLEN; i++) begin
            applyStimulus(1, 0, 0, 0, 3);
            checkOutput("t5 john");
        end
        applyStimulus(0, 0, 1, 5, 3);
        check("t5 load q", 32'(bus.o_q), 32'd5);
        applyStimulus(1, 0, 0, 0, 3);
        check("t5 illegal q", 32'(bus.o_q), 32'd0);
        check("t5 illegal wrap", 32'(bus.o_wrap), 32'd0);

        $display("[TB] random phase");
        mode = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) mode = int'($urandom_range(0, 3));
            en   = ($urandom_range(0, 9) < 7) ? 1 : 0;
            clr  = ($urandom_range(0, 19) == 0) ? 1 : 0;
            load = ($urandom_range(0, 9) == 0) ? 1 : 0;
            lv   = int'($urandom_range(0, TOP));
            applyStimulus(en, clr, load, lv, mode);
            checkOutput("rand");
        end

        $display("[TB] test 6: two-stage decimal cascade");
        @(negedge clk);
        cb1.i_clr = 1'b1; cb2.i_clr = 1'b1;
        @(negedge clk);
        cb1.i_clr = 1'b0; cb2.i_clr = 1'b0;
        cb1.i_en = 1'b1;
        wrapCount = 0;
        for (int k = 1; k <= 103; k++) begin
            @(posedge clk);
            #1;
            check("t6 value", 32'(int'(cb2.o_q) * 10 + int'(cb1.o_q)), 32'(k % 100));
            if (cb2.o_wrap === 1'b1) wrapCount++;
        end
        check("t6 stage2 wraps", 32'(wrapCount), 32'd1);
        cb1.i_en = 1'b0;
        holdVal = 3;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("t6 hold", 32'(int'(cb2.o_q) * 10 + int'(cb1.o_q)), 32'(holdVal));
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
